// File: rtl/fetch_unit.sv
// Instruction fetch: two-word reset-vector load, then sequential fetch with stall, redirect and halt.
// Packet outputs are combinational from state/pc/imem_rdata; pc, state, vec_lo, fetch_count are registered.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [47:0] packet,
  output logic        packet_valid,
  output logic        flush_out,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN, HALT} state_t;

  localparam logic [47:0] NOP_PACKET = {32'd0, 16'hE200};
  localparam logic [7:0]  HLT_OPCODE = 8'h01;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [15:0] vec_lo;
  logic        is_hlt;
  logic        take_redirect;
  logic        accept;

  assign is_hlt        = (imem_rdata[15:8] == HLT_OPCODE);
  assign take_redirect = redirect_valid && ((state == RUN) || (state == HALT));
  assign accept        = (state == RUN) && !redirect_valid && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= VEC_LO;
    end else begin
      state <= state_next;
    end
  end

  // Redirect takes priority over both stall and a pending HLT.
  always_comb begin
    state_next = state;
    case (state)
      VEC_LO: state_next = VEC_HI;
      VEC_HI: state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          state_next = RUN;
        end else if (accept && is_hlt) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          state_next = RUN;
        end
      end
      default: state_next = VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= 32'd0;
      vec_lo      <= 16'd0;
      fetch_count <= 32'd0;
    end else begin
      if (state == VEC_LO) begin
        vec_lo <= imem_rdata;
      end
      if (state == VEC_HI) begin
        pc <= {imem_rdata, vec_lo};
      end else if (take_redirect) begin
        pc <= redirect_pc;
      end else if (accept) begin
        pc          <= pc + 32'd1;
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

  // Reset gating keeps outputs quiet even while the state register still shows RUN/HALT.
  always_comb begin
    imem_addr    = pc;
    packet       = NOP_PACKET;
    packet_valid = 1'b0;
    flush_out    = 1'b0;
    halted       = 1'b0;
    case (state)
      VEC_LO: imem_addr = 32'd0;
      VEC_HI: imem_addr = 32'd1;
      RUN: begin
        if (!reset && !redirect_valid) begin
          packet_valid = 1'b1;
          packet       = {pc, imem_rdata};
        end
        flush_out = !reset && redirect_valid;
      end
      HALT: begin
        halted    = !reset;
        flush_out = !reset && redirect_valid;
      end
      default: imem_addr = pc;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_fetch_unit;

  localparam logic [47:0] NOP_PKT = {32'd0, 16'hE200};

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [47:0] packet;
  logic        packet_valid;
  logic        flush_out;
  logic        halted;
  logic [31:0] fetch_count;

  logic [15:0] mem [0:255];

  typedef struct {
    logic        vld;
    logic [47:0] pkt;
    logic        flush;
    logic        hlt;
    logic [31:0] addr;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks;
  int          failures;
  int          cyc;
  logic [31:0] exp_fc;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .packet         (packet),
    .packet_valid   (packet_valid),
    .flush_out      (flush_out),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always_comb imem_rdata = mem[imem_addr[7:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        cyc++;
        chk("packet_valid", {63'd0, packet_valid}, {63'd0, mon_e.vld});
        chk("packet",       {16'd0, packet},       {16'd0, mon_e.pkt});
        chk("flush_out",    {63'd0, flush_out},    {63'd0, mon_e.flush});
        chk("halted",       {63'd0, halted},       {63'd0, mon_e.hlt});
        chk("imem_addr",    {32'd0, imem_addr},    {32'd0, mon_e.addr});
        chk("fetch_count",  {32'd0, fetch_count},  {32'd0, mon_e.fc});
      end
    end
  end

  // One clock of stimulus plus the expected outputs for that clock.
  task automatic step(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic ef, input logic eh,
                      input logic [31:0] ea);
    exp_t e;
    reset          = rst;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.vld   = ev;
    e.pkt   = ev ? {epc, mem[epc[7:0]]} : NOP_PKT;
    e.flush = ef;
    e.hlt   = eh;
    e.addr  = ea;
    e.fc    = exp_fc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (rst) exp_fc = 32'd0;
    else if (ev && !stl) exp_fc = exp_fc + 32'd1;
  endtask

  // Accepted sequential fetch at pc p.
  task automatic run(input logic [31:0] p);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, p, 1'b0, 1'b0, p);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_fc   = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = {8'h20, i[7:0]};
    mem[0]     = 16'h0010;
    mem[1]     = 16'h0000;
    mem[8'h40] = 16'h0155;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset held, with redirect asserted: quiet outputs, vector address 0.
    step(1'b1, 1'b0, 1'b1, 32'h999, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    // Boot from vector 0x10.
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd1);
    run(32'h10);
    run(32'h11);
    // Redirect to 0x20, then stall three cycles.
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'd0, 1'b1, 1'b0, 32'h12);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h20);
    run(32'h20);
    run(32'h21);
    // Redirect to 0x30, then redirect+stall together.
    step(1'b0, 1'b0, 1'b1, 32'h30,  1'b0, 32'd0, 1'b1, 1'b0, 32'h22);
    step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b0, 32'h30);
    run(32'h100);
    // HLT at 0x40: stalled first, then accepted, then halted.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1, 1'b0, 32'h101);
    step(1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 32'h40, 1'b0, 1'b0, 32'h40);
    run(32'h40);
    step(1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 1'b1, 32'h41);
    step(1'b0, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0, 1'b0, 1'b1, 32'h41);
    step(1'b0, 1'b1, 1'b1, 32'h50, 1'b0, 32'd0, 1'b1, 1'b1, 32'h41);
    run(32'h50);
    // Reset at pc 0x77 with redirect asserted; vector fetch ignores redirect.
    step(1'b0, 1'b0, 1'b1, 32'h77,  1'b0, 32'd0, 1'b1, 1'b0, 32'h51);
    step(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0, 32'h77);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 1'b0, 32'd1);
    run(32'h10);
    run(32'h11);
    // PC wrap from vector 0xFFFFFFFF.
    mem[0] = 16'hFFFF;
    mem[1] = 16'hFFFF;
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h12);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd1);
    run(32'hFFFF_FFFF);
    run(32'h0000_0000);
    run(32'h0000_0001);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
